// File: rtl/regs_wb_ctrl_pkg.sv
// Shared register-file geometry and write-back source tags for the write-side controller.
package regs_wb_ctrl_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CPU_WIDTH      = 32;
    localparam int DEF_REG_DATA_DEPTH = 32;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LL  = 1'b1;

endpackage

// File: rtl/regs_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set on long-latency issue,
// cleared when that register's long-latency result commits; set wins over clear.
module regs_scoreboard import regs_wb_ctrl_pkg::*; #(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int REG_DATA_DEPTH = DEF_REG_DATA_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_rd_i,
    input  logic                      clr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] clr_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_adder_i,
    output logic                      hazard_stall_o
);

    logic [REG_DATA_DEPTH-1:0] pending_q;
    logic [REG_DATA_DEPTH-1:0] pending_d;
    logic [REG_DATA_DEPTH-1:0] set_mask;
    logic [REG_DATA_DEPTH-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i && (set_rd_i != '0)) set_mask[set_rd_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_rd_i] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign hazard_stall_o = ((rs1_adder_i != '0) && pending_q[rs1_adder_i]) ||
                            ((rs2_adder_i != '0) && pending_q[rs2_adder_i]) ||
                            ((rd_adder_i  != '0) && pending_q[rd_adder_i]);

endmodule

// File: rtl/regs_wb_ctrl.sv
// Register-file write-port arbiter: ALU first, then the one-entry skid buffer, then a
// direct long-latency result; registered write outputs carry a source tag for the scoreboard.
module regs_wb_ctrl import regs_wb_ctrl_pkg::*; #(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CPU_WIDTH      = DEF_CPU_WIDTH,
    parameter int REG_DATA_DEPTH = DEF_REG_DATA_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_wr_adder_i,
    input  logic [CPU_WIDTH-1:0]      alu_wr_data_i,
    input  logic                      ll_issue_i,
    input  logic [REG_ADDR_WIDTH-1:0] ll_issue_rd_i,
    input  logic                      ll_valid_i,
    output logic                      ll_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] ll_rd_i,
    input  logic [CPU_WIDTH-1:0]      ll_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_adder_i,
    output logic                      hazard_stall_o,
    output logic                      reg_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_o,
    output logic [CPU_WIDTH-1:0]      reg_wr_data_o
);

    logic                      skid_full_q,    skid_full_d;
    logic [REG_ADDR_WIDTH-1:0] skid_rd_q,      skid_rd_d;
    logic [CPU_WIDTH-1:0]      skid_data_q,    skid_data_d;
    logic                      reg_wr_en_q,    reg_wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_q, reg_wr_adder_d;
    logic [CPU_WIDTH-1:0]      reg_wr_data_q,  reg_wr_data_d;
    logic                      reg_wr_src_q,   reg_wr_src_d;
    logic                      ll_hs;
    logic                      wr_sel;

    always_comb begin
        ll_hs          = ll_valid_i && !skid_full_q;
        wr_sel         = 1'b0;
        reg_wr_adder_d = reg_wr_adder_q;
        reg_wr_data_d  = reg_wr_data_q;
        reg_wr_src_d   = reg_wr_src_q;
        skid_full_d    = skid_full_q;
        skid_rd_d      = skid_rd_q;
        skid_data_d    = skid_data_q;
        if (alu_wr_en_i) begin
            wr_sel         = 1'b1;
            reg_wr_adder_d = alu_wr_adder_i;
            reg_wr_data_d  = alu_wr_data_i;
            reg_wr_src_d   = WB_SRC_ALU;
            if (ll_hs) begin
                skid_full_d = 1'b1;
                skid_rd_d   = ll_rd_i;
                skid_data_d = ll_data_i;
            end
        end else if (skid_full_q) begin
            wr_sel         = 1'b1;
            reg_wr_adder_d = skid_rd_q;
            reg_wr_data_d  = skid_data_q;
            reg_wr_src_d   = WB_SRC_LL;
            skid_full_d    = 1'b0;
        end else if (ll_hs) begin
            wr_sel         = 1'b1;
            reg_wr_adder_d = ll_rd_i;
            reg_wr_data_d  = ll_data_i;
            reg_wr_src_d   = WB_SRC_LL;
        end
        // x0 is hardwired zero: address/data still move, only the enable is withheld
        reg_wr_en_d = wr_sel && (reg_wr_adder_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_full_q    <= 1'b0;
            skid_rd_q      <= '0;
            skid_data_q    <= '0;
            reg_wr_en_q    <= 1'b0;
            reg_wr_adder_q <= '0;
            reg_wr_data_q  <= '0;
            reg_wr_src_q   <= WB_SRC_ALU;
        end else begin
            skid_full_q    <= skid_full_d;
            skid_rd_q      <= skid_rd_d;
            skid_data_q    <= skid_data_d;
            reg_wr_en_q    <= reg_wr_en_d;
            reg_wr_adder_q <= reg_wr_adder_d;
            reg_wr_data_q  <= reg_wr_data_d;
            reg_wr_src_q   <= reg_wr_src_d;
        end
    end

    assign ll_ready_o     = !skid_full_q;
    assign reg_wr_en_o    = reg_wr_en_q;
    assign reg_wr_adder_o = reg_wr_adder_q;
    assign reg_wr_data_o  = reg_wr_data_q;

    regs_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .REG_DATA_DEPTH (REG_DATA_DEPTH)
    ) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_en_i       (ll_issue_i),
        .set_rd_i       (ll_issue_rd_i),
        .clr_en_i       (reg_wr_en_q && (reg_wr_src_q == WB_SRC_LL)),
        .clr_rd_i       (reg_wr_adder_q),
        .rs1_adder_i    (rs1_adder_i),
        .rs2_adder_i    (rs2_adder_i),
        .rd_adder_i     (rd_adder_i),
        .hazard_stall_o (hazard_stall_o)
    );

endmodule
